// File: rtl/regfile_wb_scoreboard.sv
// MIPS integer register file with per-register pending-write scoreboard.
// Optional same-cycle WB->ID bypass compiled in with REGFILE_BYPASS_EN.
module regfile_wb_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RsAddr_id,
  input  logic [ADDR_W-1:0] RtAddr_id,
  output logic [DATA_W-1:0] RsData_id,
  output logic [DATA_W-1:0] RtData_id,
  output logic              RsBusy_id,
  output logic              RtBusy_id,
  input  logic              Issue_id,
  input  logic [ADDR_W-1:0] IssueAddr_id,
  input  logic              RegWrite_wb,
  input  logic [ADDR_W-1:0] RegWriteAddr_wb,
  input  logic [DATA_W-1:0] RegWriteData_wb,
  output logic              SbError
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              err_q, err_d;

  logic              wb_en;
  logic [DATA_W-1:0] rs_arr, rt_arr;
  logic              rs_cnt_nz, rt_cnt_nz;

  // Register 0 is architecturally zero: writes, issues and retires to it are ignored.
  assign wb_en = RegWrite_wb && (RegWriteAddr_wb != '0);

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NREG; r++) begin
      if (Issue_id && (IssueAddr_id == ADDR_W'(r)) &&
          !(RegWrite_wb && (RegWriteAddr_wb == ADDR_W'(r)))) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (RegWrite_wb && (RegWriteAddr_wb == ADDR_W'(r)) &&
                   !(Issue_id && (IssueAddr_id == ADDR_W'(r)))) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wb_en) regs_q[RegWriteAddr_wb] <= RegWriteData_wb;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign rs_arr    = (RsAddr_id == '0) ? '0 : regs_q[RsAddr_id];
  assign rt_arr    = (RtAddr_id == '0) ? '0 : regs_q[RtAddr_id];
  assign rs_cnt_nz = (RsAddr_id != '0) && (cnt_q[RsAddr_id] != '0);
  assign rt_cnt_nz = (RtAddr_id != '0) && (cnt_q[RtAddr_id] != '0);
  assign SbError   = err_q;

`ifdef REGFILE_BYPASS_EN
  // A retire of the last pending writer is visible to ID in the same cycle.
  assign RsData_id = (wb_en && (RegWriteAddr_wb == RsAddr_id)) ? RegWriteData_wb : rs_arr;
  assign RtData_id = (wb_en && (RegWriteAddr_wb == RtAddr_id)) ? RegWriteData_wb : rt_arr;
  assign RsBusy_id = rs_cnt_nz &&
                     !(wb_en && (RegWriteAddr_wb == RsAddr_id) && (cnt_q[RsAddr_id] == CNT_ONE));
  assign RtBusy_id = rt_cnt_nz &&
                     !(wb_en && (RegWriteAddr_wb == RtAddr_id) && (cnt_q[RtAddr_id] == CNT_ONE));
`else
  assign RsData_id = rs_arr;
  assign RtData_id = rt_arr;
  assign RsBusy_id = rs_cnt_nz;
  assign RtBusy_id = rt_cnt_nz;
`endif

endmodule
